hack_fetch_pc: RTL and testbench

Program-counter and instruction-fetch stage of the Hack CPU. Holds the 16-bit PC, fetches each instruction from instruction ROM over a req/ack handshake, and presents the captured instruction to the execute datapath. At instruction retirement it evaluates the C-instruction jump condition against the ALU flags and selects the next PC: the A-register value or PC+1. This is the word-wide selection that feeds the downstream 16-bit multiplexer path.

---
 rtl/hack_pkg.sv | 19 +
 rtl/hack_jump_cond.sv | 24 ++
 rtl/hack_fetch_pc.sv | 113 +++++++++++
 tb/tb_hack_fetch_pc.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU fetch and decode blocks.
// Holds the word width, the fetch FSM states and the C-instruction bit map.
package hack_pkg;

    localparam int WORD_W = 16;

    // C-instruction marker bit and jump field bit positions
    localparam int C_BIT  = 15;
    localparam int J1_BIT = 2;
    localparam int J2_BIT = 1;
    localparam int J3_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump-condition evaluator for Hack C-instructions.
// Shared between the fetch stage and the CPU decode block.
module hack_jump_cond (
    input  logic       i_c,
    input  logic [2:0] i_j,
    input  logic       i_zr,
    input  logic       i_ng,
    output logic       o_take
);

    logic w_lt;
    logic w_eq;
    logic w_gt;

    // Decode the three jump bits (lt, eq, gt) against the ALU flags.
    // Only a C-instruction can ever jump.
    always_comb begin
        w_lt   = i_j[2] & i_ng;
        w_eq   = i_j[1] & i_zr;
        w_gt   = i_j[0] & ~i_zr & ~i_ng;
        o_take = i_c & (w_lt | w_eq | w_gt);
    end

endmodule

// File: rtl/hack_fetch_pc.sv
// Hack CPU program counter and instruction-fetch stage.
// Fetches over a req/ack ROM port and picks A or PC+1 at retirement.
module hack_fetch_pc
    import hack_pkg::*;
#(
    parameter int               WIDTH      = WORD_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_reset,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             exec_done,
    input  logic             alu_zr,
    input  logic             alu_ng,
    input  logic [WIDTH-1:0] a_in,
    output logic             rom_req,
    output logic [WIDTH-1:0] rom_addr,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             jump_taken
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] w_instr_nxt;
    logic             r_jump;
    logic             w_jump_nxt;

    logic             w_take;
    logic [2:0]       w_jbits;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_next_pc;

    assign w_jbits = {r_instr[J1_BIT], r_instr[J2_BIT], r_instr[J3_BIT]};

    hack_jump_cond u_jump_cond (
        .i_c    (r_instr[C_BIT]),
        .i_j    (w_jbits),
        .i_zr   (alu_zr),
        .i_ng   (alu_ng),
        .o_take (w_take)
    );

    // Next PC: jump target from A, else sequential (wraps modulo 2^WIDTH).
    always_comb begin
        w_pc_inc  = r_pc + WIDTH'(1);
        w_next_pc = w_take ? a_in : w_pc_inc;
    end

    // FSM next-state plus PC/instr/jump-pulse updates; soft_reset wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_jump_nxt  = 1'b0;
        if (soft_reset) begin
            w_state_nxt = IDLE;
            w_pc_nxt    = RESET_ADDR;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = FETCH;
                end
                FETCH: begin
                    if (rom_ack) begin
                        w_instr_nxt = rom_data;
                        w_state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        w_pc_nxt    = w_next_pc;
                        w_jump_nxt  = w_take;
                        w_state_nxt = FETCH;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, PC, instruction and jump-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_ADDR;
            r_instr <= '0;
            r_jump  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_jump  <= w_jump_nxt;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        rom_req     = (r_state == FETCH);
        instr_valid = (r_state == EXEC);
        rom_addr    = r_pc;
        instr       = r_instr;
        jump_taken  = r_jump;
    end

endmodule

// File: tb/tb_hack_fetch_pc.sv
// Self-checking bench for hack_fetch_pc.
// Randomized fetch/execute traffic against a behavioural PC model.
module tb_hack_fetch_pc;

    logic        clk;
    logic        rst_n;
    logic        soft_reset;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        exec_done;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_in;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        jump_taken;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_pc;

    hack_fetch_pc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_reset  (soft_reset),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .exec_done   (exec_done),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .a_in        (a_in),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .jump_taken  (jump_taken)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // Reference: classify the ALU result as <0, ==0, >0 and test that
    // class against the three jump bits of a C-instruction.
    function automatic logic [15:0] ref_next(input logic [15:0] pc,
                                             input logic [15:0] ins,
                                             input logic [15:0] a,
                                             input logic zr,
                                             input logic ng,
                                             output logic tk);
        int cls;
        int nxt;
        cls = ng ? 4 : (zr ? 2 : 1);
        tk  = (ins >= 16'h8000) && ((int'(ins % 8) & cls) != 0);
        nxt = (int'(pc) + 1) % 65536;
        return tk ? a : 16'(nxt);
    endfunction

    // One full instruction: stall ackd cycles in FETCH, capture d, sit in
    // EXEC for doned cycles (with stray acks), then retire.
    task automatic fetch_exec(input logic [15:0] d, input int ackd,
                              input int doned, input logic zr,
                              input logic ng, input logic [15:0] a,
                              output logic [15:0] o_addr,
                              output logic [15:0] o_instr,
                              output logic o_iv,
                              output logic [15:0] o_next,
                              output logic o_req,
                              output logic o_jt,
                              output logic o_jt2,
                              output logic o_bad);
        o_bad  = 0;
        o_addr = rom_addr;
        rom_ack = 0;
        exec_done = 0;
        for (int i = 0; i < ackd; i++) begin
            rom_data = 16'($urandom);
            if (rom_req !== 1'b1 || rom_addr !== o_addr ||
                instr_valid !== 1'b0)
                o_bad = 1;
            @(negedge clk);
        end
        if (rom_req !== 1'b1 || rom_addr !== o_addr) o_bad = 1;
        rom_data = d;
        rom_ack = 1;
        @(negedge clk);
        rom_ack = 0;
        o_instr = instr;
        o_iv = instr_valid;
        alu_zr = zr;
        alu_ng = ng;
        a_in = a;
        for (int i = 0; i < doned; i++) begin
            rom_ack = 1;
            rom_data = ~d;
            @(negedge clk);
            rom_ack = 0;
            if (instr !== d || instr_valid !== 1'b1 ||
                jump_taken !== 1'b0)
                o_bad = 1;
        end
        exec_done = 1;
        @(negedge clk);
        exec_done = 0;
        o_next = rom_addr;
        o_req = rom_req;
        o_jt = jump_taken;
        @(negedge clk);
        o_jt2 = jump_taken;
    endtask

    task automatic bring_up();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        exp_pc = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 0;
        soft_reset = 0;
        rom_ack = 0;
        rom_data = 0;
        exec_done = 0;
        alu_zr = 0;
        alu_ng = 0;
        a_in = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_req, instr_valid, jump_taken} !== 3'b000 ||
            rom_addr !== 16'h0 || instr !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b iv=%b jt=%b addr=%h instr=%h, required 0",
                     rom_req, instr_valid, jump_taken, rom_addr, instr);
        end
        rst_n = 1;
        #1;
        checks++;
        if (rom_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cycle: rom_req=%b, required 0", rom_req);
        end
        @(negedge clk);
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_first_fetch: req=%b addr=%h, required 1 0000",
                     rom_req, rom_addr);
        end
        exp_pc = 16'h0000;
    endtask

    task automatic test_sequential();
        logic [15:0] ad, ins, nx;
        logic iv, rq, jt, jt2, bad;
        for (int k = 0; k < 4; k++) begin
            fetch_exec(16'h0005, 0, 0, 0, 0, 16'h7777,
                       ad, ins, iv, nx, rq, jt, jt2, bad);
            checks++;
            if (ad !== 16'(k) || ins !== 16'h0005 || iv !== 1'b1 ||
                nx !== 16'(k + 1) || rq !== 1'b1 || jt !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: addr=%h instr=%h iv=%b next=%h req=%b jt=%b, required %h 0005 1 %h 1 0",
                         k, ad, ins, iv, nx, rq, jt, 16'(k), 16'(k + 1));
            end
        end
        exp_pc = 16'h0004;
    endtask

    task automatic test_jumps();
        logic [15:0] ad, ins, nx;
        logic iv, rq, jt, jt2, bad;
        fetch_exec(16'hE302, 0, 1, 1, 0, 16'h0040,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (nx !== 16'h0040 || jt !== 1'b1 || jt2 !== 1'b0 || bad) begin
            errors++;
            $display("FAIL jeq_taken: next=%h jt=%b jt_after=%b bad=%b, required 0040 1 0 0",
                     nx, jt, jt2, bad);
        end
        fetch_exec(16'hE302, 0, 0, 0, 0, 16'h0900,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (nx !== 16'h0041 || jt !== 1'b0) begin
            errors++;
            $display("FAIL jeq_not_taken: next=%h jt=%b, required 0041 0",
                     nx, jt);
        end
        fetch_exec(16'hE301, 0, 0, 0, 1, 16'h0900,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (nx !== 16'h0042 || jt !== 1'b0) begin
            errors++;
            $display("FAIL jgt_neg: next=%h jt=%b, required 0042 0", nx, jt);
        end
        fetch_exec(16'h0307, 0, 0, 1, 0, 16'h0900,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (nx !== 16'h0043 || jt !== 1'b0) begin
            errors++;
            $display("FAIL a_instr_nojump: next=%h jt=%b, required 0043 0",
                     nx, jt);
        end
        exp_pc = 16'h0043;
    endtask

    task automatic test_wrap_stall();
        logic [15:0] ad, ins, nx;
        logic iv, rq, jt, jt2, bad;
        fetch_exec(16'hE307, 0, 0, 0, 0, 16'hFFFF,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (nx !== 16'hFFFF || jt !== 1'b1) begin
            errors++;
            $display("FAIL jmp_to_ffff: next=%h jt=%b, required ffff 1",
                     nx, jt);
        end
        fetch_exec(16'h1234, 5, 2, 0, 0, 16'h0100,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        checks++;
        if (bad || ad !== 16'hFFFF || ins !== 16'h1234) begin
            errors++;
            $display("FAIL stall_stable: bad=%b addr=%h instr=%h, required 0 ffff 1234",
                     bad, ad, ins);
        end
        checks++;
        if (nx !== 16'h0000 || jt !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: next=%h jt=%b, required 0000 0", nx, jt);
        end
        exp_pc = 16'h0000;
    endtask

    task automatic test_soft_reset();
        logic [15:0] held;
        // collide with exec_done on a taken JMP
        rom_data = 16'hE307;
        rom_ack = 1;
        @(negedge clk);
        rom_ack = 0;
        a_in = 16'h1234;
        exec_done = 1;
        soft_reset = 1;
        @(negedge clk);
        exec_done = 0;
        soft_reset = 0;
        checks++;
        if (rom_req !== 1'b0 || instr_valid !== 1'b0 ||
            jump_taken !== 1'b0 || rom_addr !== 16'h0000 ||
            instr !== 16'hE307) begin
            errors++;
            $display("FAIL soft_vs_exec: req=%b iv=%b jt=%b addr=%h instr=%h, required 0 0 0 0000 e307",
                     rom_req, instr_valid, jump_taken, rom_addr, instr);
        end
        @(negedge clk);
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 16'h0000 ||
            jump_taken !== 1'b0) begin
            errors++;
            $display("FAIL soft_refetch: req=%b addr=%h jt=%b, required 1 0000 0",
                     rom_req, rom_addr, jump_taken);
        end
        // collide with rom_ack: data must be discarded
        held = instr;
        rom_data = 16'hABCD;
        rom_ack = 1;
        soft_reset = 1;
        @(negedge clk);
        rom_ack = 0;
        soft_reset = 0;
        checks++;
        if (instr !== held || instr_valid !== 1'b0 || rom_req !== 1'b0) begin
            errors++;
            $display("FAIL soft_vs_ack: instr=%h iv=%b req=%b, required %h 0 0",
                     instr, instr_valid, rom_req, held);
        end
        @(negedge clk);
        exp_pc = 16'h0000;
    endtask

    task automatic test_async_reset();
        logic [15:0] ad, ins, nx;
        logic iv, rq, jt, jt2, bad;
        fetch_exec(16'hE307, 0, 0, 0, 0, 16'h0321,
                   ad, ins, iv, nx, rq, jt, jt2, bad);
        rom_data = 16'h5A5A;
        rom_ack = 1;
        @(negedge clk);
        rom_ack = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (rom_req !== 1'b0 || instr_valid !== 1'b0 ||
            jump_taken !== 1'b0 || rom_addr !== 16'h0000 ||
            instr !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: req=%b iv=%b jt=%b addr=%h instr=%h, required 0 0 0 0000 0000",
                     rom_req, instr_valid, jump_taken, rom_addr, instr);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        exp_pc = 16'h0000;
    endtask

    task automatic test_random();
        logic [15:0] ad, ins, nx, d, a, en;
        logic iv, rq, jt, jt2, bad, zr, ng, tk;
        int cls;
        for (int k = 0; k < 40; k++) begin
            d = 16'($urandom);
            a = 16'($urandom);
            cls = $urandom_range(0, 2);
            ng = (cls == 0);
            zr = (cls == 1);
            en = ref_next(exp_pc, d, a, zr, ng, tk);
            fetch_exec(d, $urandom_range(0, 3), $urandom_range(0, 3),
                       zr, ng, a, ad, ins, iv, nx, rq, jt, jt2, bad);
            checks++;
            if (ad !== exp_pc || ins !== d || iv !== 1'b1 || bad ||
                nx !== en || jt !== tk || jt2 !== 1'b0 || rq !== 1'b1) begin
                errors++;
                $display("FAIL rand_%0d: addr=%h instr=%h next=%h jt=%b bad=%b, required %h %h %h %b 0",
                         k, ad, ins, nx, jt, bad, exp_pc, d, en, tk);
            end
            exp_pc = en;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jumps();
        test_wrap_stall();
        test_soft_reset();
        test_async_reset();
        test_random();
        bring_up();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
